// File: rtl/soc_sys_pkg.sv
// Shared types and default sizing for the SoC system-register bus arbiter.
// The state encoding doubles as the one-hot grant vector.
package soc_sys_pkg;

    localparam int unsigned DefAw      = 32;
    localparam int unsigned DefDw      = 32;
    localparam int unsigned DefTimeout = 255;

    typedef enum logic [1:0] {
        Idle = 2'b00,
        Gnt0 = 2'b01,
        Gnt1 = 2'b10
    } arb_state_e;

    function automatic logic [1:0] grant_of(arb_state_e st);
        return logic'(st == Gnt1) ? 2'b10 : (st == Gnt0) ? 2'b01 : 2'b00;
    endfunction

endpackage

// File: rtl/soc_bus_timer.sv
// Stall counter for the shared slave port: counts cycles a strobe goes unanswered
// and flags when the count reaches Timeout.
module soc_bus_timer #(
    parameter int unsigned Timeout = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(Timeout + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CntW'(Timeout));

endmodule

// File: rtl/soc_sys_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the SoC register slave.
// Optional bus timeout enabled by defining SOC_SYS_ARBITER_TIMEOUT_EN.
module soc_sys_arbiter
    import soc_sys_pkg::*;
#(
    parameter int unsigned AW      = DefAw,
    parameter int unsigned DW      = DefDw,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic            sys_clk_i,
    input  logic            sys_rst_i,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,

    output logic [1:0]      grant_o
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("soc_sys_arbiter: TIMEOUT must be within 1..65535");
    end

    arb_state_e state_q, state_d;
    logic       last_q, last_d;  // last owner: 0 = m0, 1 = m1
    logic       stb_raw;
    logic       expired;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            Idle: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? Gnt0 : Gnt1;
                end else if (m0_cyc_i) begin
                    state_d = Gnt0;
                end else if (m1_cyc_i) begin
                    state_d = Gnt1;
                end
            end
            Gnt0: begin
                if (!m0_cyc_i) begin
                    state_d = Idle;
                    last_d  = 1'b0;
                end
            end
            Gnt1: begin
                if (!m1_cyc_i) begin
                    state_d = Idle;
                    last_d  = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= Idle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_of(state_q);

    assign stb_raw = ((state_q == Gnt0) && m0_stb_i) || ((state_q == Gnt1) && m1_stb_i);

`ifdef SOC_SYS_ARBITER_TIMEOUT_EN
    logic term;
    logic run;
    logic clr;

    assign term = s_ack_i | s_err_i | s_rty_i;
    assign run  = stb_raw & ~term;
    assign clr  = ~stb_raw | term | expired;

    soc_bus_timer #(
        .Timeout (TIMEOUT)
    ) u_bus_timer (
        .clk_i     (sys_clk_i),
        .rst_ni    (sys_rst_i),
        .run_i     (run),
        .clr_i     (clr),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Request fields pass straight through from the owner; responses go to the owner only.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        unique case (state_q)
            Gnt0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~expired;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | expired;
                m0_rty_o = s_rty_i;
            end
            Gnt1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~expired;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | expired;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: doc/soc_sys_arbiter.md
SOC_SYS_ARBITER -- requirements
Module: soc_sys_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 255: bus-timeout limit in cycles, range 1..65535.
REQ-004 SHALL have port sys_clk_i, in, 1: the single clock, rising edge.
REQ-005 SHALL have port sys_rst_i, in, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports mN_adr_i (AW), mN_dat_i (DW), mN_sel_i (DW/8), in, for N=0,1: master request fields.
REQ-007 SHALL have ports mN_we_i, mN_cyc_i, mN_stb_i, in, 1, for N=0,1: master Wishbone controls.
REQ-008 SHALL have ports mN_dat_o (DW) and mN_ack_o, mN_err_o, mN_rty_o (1 each), out, for N=0,1: master responses.
REQ-009 SHALL have ports s_adr_o (AW), s_dat_o (DW), s_sel_o (DW/8), s_we_o, s_cyc_o, s_stb_o (1 each), out: shared soc register slave port.
REQ-010 SHALL have ports s_dat_i (DW), s_ack_i, s_err_i, s_rty_i (1 each), in: slave responses.
REQ-011 SHALL have port grant_o, out, 2: one-hot current owner; 00 when idle.

Function
REQ-012 SHALL implement the states IDLE, GNT0 and GNT1.
REQ-013 In IDLE, all s_* outputs and all mN_ack/err/rty_o SHALL be 0.
REQ-014 In IDLE with exactly one mN_cyc_i high, the next state SHALL be GNTN.
REQ-015 In IDLE with both mN_cyc_i high, the grant SHALL go to the master other than the last owner (round-robin).
REQ-016 Last owner SHALL reset to 1, so m0 wins the first tie.
REQ-017 Grant latency SHALL be one cycle: cyc is seen in IDLE, and s_cyc_o rises on the next cycle.
REQ-018 In GNTN, s_adr/dat/sel/we/cyc/stb_o SHALL combinationally equal the master N inputs.
REQ-019 In GNTN, s_ack/err/rty_i SHALL be routed to master N only; the other master's ack/err/rty SHALL be 0.
REQ-020 mN_dat_o SHALL equal s_dat_i for both masters in all states.
REQ-021 Ownership SHALL be held for the whole tenure while mN_cyc_i=1, including multiple stb beats; a request from the other master SHALL NOT preempt it.
REQ-022 GNTN with mN_cyc_i=0 SHALL go to IDLE, set last owner to N, and drive s_cyc_o=0 in that cycle.
REQ-023 Back-to-back tenures SHALL be separated by exactly one IDLE cycle.
REQ-024 If the owner drops cyc in the same cycle as the slave acks, the ack SHALL still be forwarded and the state SHALL go to IDLE.
REQ-025 grant_o SHALL be registered state: 01 in GNT0, 10 in GNT1.

Reset
REQ-026 Assertion of sys_rst_i low SHALL immediately force IDLE, last owner=1, timeout count=0, grant_o=00, and all outputs to the IDLE values, including mid-tenure.
REQ-027 Reset release SHALL be taken synchronously; arbitration starts on the first rising edge with sys_rst_i high.

Configuration
REQ-028 Macro SOC_SYS_ARBITER_TIMEOUT_EN defined: a counter of $clog2(TIMEOUT+1) bits SHALL increment each cycle that s_stb_o=1 and s_ack_i|s_err_i|s_rty_i=0.
REQ-029 With SOC_SYS_ARBITER_TIMEOUT_EN defined, the counter SHALL clear on any termination or when s_stb_o=0.
REQ-030 With SOC_SYS_ARBITER_TIMEOUT_EN defined, when the count equals TIMEOUT the arbiter SHALL assert the owner's mN_err_o for one cycle, force s_stb_o=0 in that cycle and clear the counter.
REQ-031 Macro undefined: no counter SHALL exist, and a stalled slave SHALL hold the grant indefinitely.

Structure
REQ-032 Package soc_sys_pkg SHALL hold the state enum (IDLE, GNT0, GNT1) and the default AW, DW and TIMEOUT constants.
REQ-033 The timeout counter SHALL be sub-module soc_bus_timer (inputs: clk, rst, run, clr; output: expired), instantiated only under SOC_SYS_ARBITER_TIMEOUT_EN.

Verification
REQ-034 m0 single write: adr=0x04, dat=0xDEADBEEF, sel=F, with slave ack on the 2nd cycle -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o=1 for 1 cycle; grant_o 01 then 00.
REQ-035 Both cyc raised simultaneously after reset, each holding for 1 ack -> m0 served first, one IDLE cycle, then m1; m1_ack_o never asserts during the m0 tenure.
REQ-036 m1 raises cyc during an m0 tenure of 3 stb beats -> all 3 beats complete to m0 before grant_o switches to 10.
REQ-037 Timeout enabled, TIMEOUT=4, slave never acks -> m0_err_o pulses 4 cycles after s_stb_o rises; without the macro, s_stb_o stays high.
REQ-038 sys_rst_i pulled low mid-tenure -> s_cyc_o and grant_o drop to 0 without waiting for a clock edge; after release, a tie grants m0.
